// File: rtl/aes_pkg.sv
// Shared definitions for the AES SubBytes/ShiftRows stage: S-box tables, FSM states,
// state byte addressing. Inverse table exists only when AES_INV_EN is defined.
package aes_pkg;

  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Byte (row r, col c) of the 128-bit state sits at bits [127-32c-8r -: 8]; this returns its LSB.
  function automatic logic [6:0] byte_lsb(input logic [1:0] r, input logic [1:0] c);
    byte_lsb = 7'd120 - {c, 5'b00000} - {2'b00, r, 3'b000};
  endfunction

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

`ifdef AES_INV_EN
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
`endif

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box lookup; inverse table selectable via i_inv when AES_INV_EN is defined.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
`ifdef AES_INV_EN
  input  logic       i_inv,
`endif
  output logic [7:0] o_byte
);

  // Table lookup, forward or inverse
  always_comb begin
`ifdef AES_INV_EN
    if (i_inv) begin
      o_byte = INV_SBOX[i_byte];
    end else begin
      o_byte = SBOX[i_byte];
    end
`else
    o_byte = SBOX[i_byte];
`endif
  end

endmodule

// File: rtl/aes_sub_shift.sv
// Iterative SubBytes+ShiftRows stage: NUM_SBOX bytes per cycle, valid/ready on both sides.
// Optional inverse mode (InvShiftRows+InvSubBytes) and in_inv port under AES_INV_EN.
module aes_sub_shift
  import aes_pkg::*;
#(
  parameter int NUM_SBOX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_final,
`ifdef AES_INV_EN
  input  logic         in_inv,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_final
);

  localparam logic [CNT_W-1:0] K_STEP = CNT_W'(NUM_SBOX);
  localparam logic [CNT_W-1:0] K_END  = CNT_W'(16);

  state_e             r_state;
  logic [CNT_W-1:0]   r_k;
  logic [127:0]       r_src;
  logic [127:0]       r_res;
  logic               r_final;
  logic               r_out_valid;
`ifdef AES_INV_EN
  logic               r_inv;
`endif

  logic [CNT_W-1:0]   w_k_next;
  logic [127:0]       w_res_next;
  logic [6:0]         w_dst_lsb  [NUM_SBOX];
  logic [7:0]         w_sbox_out [NUM_SBOX];

  assign w_k_next  = r_k + K_STEP;
  assign in_ready  = !rst && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
  assign out_valid = r_out_valid;
  assign out_data  = r_res;
  assign out_final = r_final;

  // Lane g handles output position p = k+g (p = 4c+r); its source column carries the row shift.
  for (genvar g = 0; g < NUM_SBOX; g++) begin : g_lane
    logic [3:0] w_pos;
    logic [1:0] w_src_col;
    logic [7:0] w_sbox_in;

    assign w_pos = r_k[3:0] + 4'(g);
`ifdef AES_INV_EN
    assign w_src_col = r_inv ? (w_pos[3:2] - w_pos[1:0]) : (w_pos[3:2] + w_pos[1:0]);
`else
    assign w_src_col = w_pos[3:2] + w_pos[1:0];
`endif
    assign w_sbox_in    = r_src[byte_lsb(w_pos[1:0], w_src_col) +: 8];
    assign w_dst_lsb[g] = byte_lsb(w_pos[1:0], w_pos[3:2]);

    aes_sbox u_sbox (
      .i_byte (w_sbox_in),
`ifdef AES_INV_EN
      .i_inv  (r_inv),
`endif
      .o_byte (w_sbox_out[g])
    );
  end

  // Merge this cycle's substituted bytes into the result image
  always_comb begin
    w_res_next = r_res;
    for (int j = 0; j < NUM_SBOX; j++) begin
      w_res_next[w_dst_lsb[j] +: 8] = w_sbox_out[j];
    end
  end

  // Control FSM with source/result registers and registered output flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_src       <= '0;
      r_res       <= '0;
      r_final     <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef AES_INV_EN
      r_inv       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && in_ready) begin
            r_src   <= in_data;
            r_final <= in_final;
`ifdef AES_INV_EN
            r_inv   <= in_inv;
`endif
            r_k     <= '0;
            r_state <= BUSY;
          end else begin
            r_state <= IDLE;
          end
        end
        BUSY: begin
          r_res <= w_res_next;
          if (w_k_next == K_END) begin
            r_k         <= '0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_k <= w_k_next;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            // Back-to-back: a waiting block is taken in the same cycle the result leaves
            if (in_valid && in_ready) begin
              r_src   <= in_data;
              r_final <= in_final;
`ifdef AES_INV_EN
              r_inv   <= in_inv;
`endif
              r_k     <= '0;
              r_state <= BUSY;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_state <= DONE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_k         <= '0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_sub_shift.sv
// Self-checking bench for aes_sub_shift (NUM_SBOX 4, plus 1 and 16 for latency); the
// reference derives the S-box from GF(2^8) inversion and the affine map.
module tb_aes_sub_shift;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [127:0] in_data;
  logic         in_final;
`ifdef AES_INV_EN
  logic         in_inv;
`endif
  logic v4, v1, v16, r4, r1, r16, ir4, ir1, ir16, ov4, ov1, ov16, of4, of1, of16;
  logic [127:0] od4, od1, od16;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sb [256];
  logic [7:0] isb [256];

  aes_sub_shift #(.NUM_SBOX(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(ir4), .in_data(in_data), .in_final(in_final),
`ifdef AES_INV_EN
    .in_inv(in_inv),
`endif
    .out_valid(ov4), .out_ready(r4), .out_data(od4), .out_final(of4));

  aes_sub_shift #(.NUM_SBOX(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir1), .in_data(in_data), .in_final(in_final),
`ifdef AES_INV_EN
    .in_inv(in_inv),
`endif
    .out_valid(ov1), .out_ready(r1), .out_data(od1), .out_final(of1));

  aes_sub_shift #(.NUM_SBOX(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(ir16), .in_data(in_data), .in_final(in_final),
`ifdef AES_INV_EN
    .in_inv(in_inv),
`endif
    .out_valid(ov16), .out_ready(r16), .out_data(od16), .out_final(of16));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [127:0] ref_block(input logic [127:0] d, input bit inv);
    logic [127:0] o;
    logic [7:0]   b;
    int           sc;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sc = inv ? (c - r + 4) % 4 : (c + r) % 4;
        b = d[127 - 32*sc - 8*r -: 8];
        o[127 - 32*c - 8*r -: 8] = inv ? isb[b] : sb[b];
      end
    end
    return o;
  endfunction

  // Offer one block to the 4-lane DUT (out_ready=1) and wait for its result.
  task automatic send(input logic [127:0] d, input bit f, input bit inv,
                      output int lat, output logic [127:0] got, output logic gotf);
    int cnt;
    in_data = d; in_final = f;
`ifdef AES_INV_EN
    in_inv = inv;
`endif
    v4 = 1'b1; r4 = 1'b1; #1;
    cnt = 0;
    while (!ir4 && cnt < 50) begin @(posedge clk); #1; cnt++; end
    check("accept_wait", 128'(cnt < 50), 128'(1));
    @(posedge clk); #1;
    v4 = 1'b0;
    lat = 0;
    while (!ov4 && lat < 50) begin @(posedge clk); #1; lat++; end
    got = od4; gotf = of4;
  endtask

  initial begin
    logic [127:0] d, da, db, got;
    logic         gf, fb, seen;
    logic [7:0]   inv8, s;
    int           lat, l1, l4, l16;
    logic [127:0] o1, o4, o16;
    logic         f1, f4, f16;

    for (int x = 0; x < 256; x++) begin
      inv8 = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv8 = 8'(y);
      s = inv8 ^ rotl(inv8, 1) ^ rotl(inv8, 2) ^ rotl(inv8, 3) ^ rotl(inv8, 4) ^ 8'h63;
      sb[x] = s;
      isb[s] = 8'(x);
    end

    rst = 1'b1; in_data = '0; in_final = 1'b0;
`ifdef AES_INV_EN
    in_inv = 1'b0;
`endif
    v4 = 1'b0; v1 = 1'b0; v16 = 1'b0; r4 = 1'b1; r1 = 1'b1; r16 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 128'(ir4), 128'(0));
    check("rst_out_valid", 128'(ov4), 128'(0));
    check("rst_out_data", od4, 128'h0);
    check("rst_out_final", 128'(of4), 128'(0));
    rst = 1'b0; #1;
    check("post_rst_in_ready", 128'({ir1, ir4, ir16}), 128'(3'b111));

    // FIPS-197 round-1 vector
    send(128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 1'b0, lat, got, gf);
    check("fips_data", got, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
    check("fips_latency", 128'(lat), 128'(4));
    @(posedge clk); #1;

    // All-zero final block on all three sizes at once
    in_data = '0; in_final = 1'b1;
    v4 = 1'b1; v1 = 1'b1; v16 = 1'b1;
    @(posedge clk); #1;
    v4 = 1'b0; v1 = 1'b0; v16 = 1'b0;
    l1 = 0; l4 = 0; l16 = 0; o1 = '0; o4 = '0; o16 = '0; f1 = 1'b0; f4 = 1'b0; f16 = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      if (ov1 && l1 == 0) begin l1 = cyc; o1 = od1; f1 = of1; end
      if (ov4 && l4 == 0) begin l4 = cyc; o4 = od4; f4 = of4; end
      if (ov16 && l16 == 0) begin l16 = cyc; o16 = od16; f16 = of16; end
    end
    check("zero_data_n4", o4, {16{8'h63}});
    check("zero_data_n1", o1, {16{8'h63}});
    check("zero_data_n16", o16, {16{8'h63}});
    check("zero_final", 128'({f1, f4, f16}), 128'(3'b111));
    check("latency_n4", 128'(l4), 128'(4));
    check("latency_n1", 128'(l1), 128'(16));
    check("latency_n16", 128'(l16), 128'(1));

    // Random blocks, back-to-back acceptance
    for (int i = 0; i < 8; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      fb = 1'($urandom_range(0, 1));
      send(d, fb, 1'b0, lat, got, gf);
      check("rand_data", got, ref_block(d, 1'b0));
      check("rand_final", 128'(gf), 128'(fb));
      check("rand_latency", 128'(lat), 128'(4));
    end
    @(posedge clk); #1;

    // Backpressure: result held 10 cycles while a second block waits
    da = {$urandom, $urandom, $urandom, $urandom};
    db = {$urandom, $urandom, $urandom, $urandom};
    in_data = da; in_final = 1'b0; v4 = 1'b1; r4 = 1'b0;
    @(posedge clk); #1;
    in_data = db; in_final = 1'b1;
    lat = 0;
    while (!ov4 && lat < 50) begin @(posedge clk); #1; lat++; end
    check("bp_first_latency", 128'(lat), 128'(4));
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_data", od4, ref_block(da, 1'b0));
      check("bp_in_ready_low", 128'({ir4, ov4}), 128'(2'b01));
      @(posedge clk); #1;
    end
    r4 = 1'b1; #1;
    check("bp_in_ready_rise", 128'(ir4), 128'(1));
    @(posedge clk); #1;
    v4 = 1'b0;
    lat = 0;
    while (!ov4 && lat < 50) begin @(posedge clk); #1; lat++; end
    check("bp_second_latency", 128'(lat), 128'(4));
    check("bp_second_data", od4, ref_block(db, 1'b0));
    check("bp_second_final", 128'(of4), 128'(1));

    // Reset in the second BUSY cycle drops the block
    in_data = {$urandom, $urandom, $urandom, $urandom}; v4 = 1'b1; #1;
    lat = 0;
    while (!ir4 && lat < 50) begin @(posedge clk); #1; lat++; end
    @(posedge clk); #1;
    v4 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    check("midrst_in_ready", 128'(ir4), 128'(0));
    @(posedge clk); #1;
    check("midrst_out", {od4[126:0], ov4}, 128'h0);
    check("midrst_final", 128'(of4), 128'(0));
    rst = 1'b0; #1;
    check("midrst_ready_after", 128'(ir4), 128'(1));
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (ov4) seen = 1'b1; end
    check("midrst_no_output", 128'(seen), 128'(0));
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, 1'b1, 1'b0, lat, got, gf);
    check("midrst_fresh_data", got, ref_block(d, 1'b0));
    check("midrst_fresh_latency", 128'(lat), 128'(4));

`ifdef AES_INV_EN
    send(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 1'b1, lat, got, gf);
    check("inv_fips_data", got, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    for (int i = 0; i < 6; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send(d, 1'b0, 1'(i % 2), lat, got, gf);
      check("inv_alt_data", got, ref_block(d, 1'(i % 2)));
    end
`endif

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
